// File: rtl/keypad_cursor_ctrl.sv
// rtl/keypad_cursor_ctrl.sv - keypad cursor sequencer with debounced buttons and key event handshake
//
// Purpose: turns five raw push-buttons into a wrapping row/column cursor and,
// on select, presents the linear key index to the calculator core.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   btn_up/down/left/right/sel  raw active-high buttons, asynchronous to clk
//   key_ready             consumer accepts the pending key event
//   PosHor, PosVer        registered cursor column / row
//   key_valid, key_pos    pending key event and its index PosVer*COLS+PosHor
//   overrun               one-cycle pulse when a select press is dropped
module keypad_cursor_ctrl #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       key_ready,
  output logic [2:0] PosHor,
  output logic [2:0] PosVer,
  output logic       key_valid,
  output logic [4:0] key_pos,
  output logic       overrun
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [2:0] ROW_MAX = 3'(ROWS - 1);
  localparam logic [2:0] COL_MAX = 3'(COLS - 1);

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int SEL   = 4;

  typedef enum logic {IDLE, PEND} state_t;

  logic [4:0]    btnRaw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [4:0]    press;
  logic [CW-1:0] dbCnt [5];

  state_t     state;
  state_t     stateNext;
  logic [4:0] keyPosNext;
  logic       overrunNext;
  logic [2:0] horNext;
  logic [2:0] verNext;
  logic [4:0] curPos;

  assign btnRaw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  // Synchronizer and debouncer per button. The press pulse is registered at
  // the same edge the stable level rises, so it is high for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 5; i++) begin
        dbCnt[i] <= '0;
      end
    end else begin
      sync1 <= btnRaw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != stable[i]) begin
          if (dbCnt[i] == CNT_LAST) begin
            stable[i] <= ~stable[i];
            press[i]  <= ~stable[i];
            dbCnt[i]  <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 1'b1;
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  // Opposing presses in the same cycle cancel; orthogonal ones both apply.
  always_comb begin
    verNext = PosVer;
    horNext = PosHor;
    if (press[UP] && !press[DOWN]) begin
      verNext = (PosVer == 3'd0) ? ROW_MAX : PosVer - 3'd1;
    end else if (press[DOWN] && !press[UP]) begin
      verNext = (PosVer == ROW_MAX) ? 3'd0 : PosVer + 3'd1;
    end
    if (press[LEFT] && !press[RIGHT]) begin
      horNext = (PosHor == 3'd0) ? COL_MAX : PosHor - 3'd1;
    end else if (press[RIGHT] && !press[LEFT]) begin
      horNext = (PosHor == COL_MAX) ? 3'd0 : PosHor + 3'd1;
    end
  end

  // Event index always uses the pre-move cursor.
  assign curPos = 5'(PosVer) * 5'(COLS) + 5'(PosHor);

  always_comb begin
    stateNext   = state;
    keyPosNext  = key_pos;
    overrunNext = 1'b0;
    case (state)
      IDLE: begin
        if (press[SEL]) begin
          stateNext  = PEND;
          keyPosNext = curPos;
        end
      end
      PEND: begin
        if (key_ready) begin
          // A select landing on the handshake cycle starts the next event.
          if (press[SEL]) begin
            keyPosNext = curPos;
          end else begin
            stateNext = IDLE;
          end
        end else if (press[SEL]) begin
          overrunNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_pos <= '0;
      overrun <= 1'b0;
      PosHor  <= '0;
      PosVer  <= '0;
    end else begin
      state   <= stateNext;
      key_pos <= keyPosNext;
      overrun <= overrunNext;
      PosHor  <= horNext;
      PosVer  <= verNext;
    end
  end

  assign key_valid = (state == PEND);

endmodule
